// File: rtl/rf_arbiter.sv
//==============================================================================
// Module   : rf_arbiter
// Purpose  : Two-requester arbiter in front of a 4-entry register file
//            (IDLE -> ACCESS -> DONE). Define RF_ARB_RR_EN for round-robin
//            arbitration; otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_arbiter #(
    parameter int DW = 4,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [RW-1:0] reg_no0,
    input  logic [RW-1:0] reg_no1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rf_write_en,
    output logic [RW-1:0] rf_reg_no,
    output logic [DW-1:0] rf_val,
    input  logic [DW-1:0] rf_dout,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          id_q;
    logic          we_q;
    logic [RW-1:0] reg_no_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          w_gnt;
    logic          w_start;
    logic          w_bad_reg;

    assign w_start   = (state_q == IDLE) && (req0 || req1);
    assign w_bad_reg = (reg_no_q > RW'(3));

`ifdef RF_ARB_RR_EN
    // Pointer holds the id of the most recent grant; the other requester
    // wins when both ask.
    logic last_q;

    always_comb begin
        if (req0 && req1) begin
            w_gnt = ~last_q;
        end else begin
            w_gnt = ~req0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (w_start) begin
            last_q <= w_gnt;
        end
    end
`else
    assign w_gnt = ~req0;
`endif

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (req0 || req1) ? ACCESS : IDLE;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            reg_no_q <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_start) begin
                id_q     <= w_gnt;
                we_q     <= w_gnt ? we1 : we0;
                reg_no_q <= w_gnt ? reg_no1 : reg_no0;
                wdata_q  <= w_gnt ? wdata1 : wdata0;
            end
            // Out-of-range registers read back as zero regardless of rf_dout.
            if (state_q == ACCESS) begin
                if (id_q) begin
                    rdata1_q <= w_bad_reg ? '0 : rf_dout;
                end else begin
                    rdata0_q <= w_bad_reg ? '0 : rf_dout;
                end
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign rf_write_en = (state_q == ACCESS) && we_q && !w_bad_reg;
    assign rf_reg_no   = (state_q == ACCESS) ? reg_no_q : '0;
    assign rf_val      = (state_q == ACCESS) ? wdata_q : '0;

    assign ack0   = (state_q == DONE) && !id_q;
    assign ack1   = (state_q == DONE) && id_q;
    assign err0   = ack0 && w_bad_reg;
    assign err1   = ack1 && w_bad_reg;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_arbiter.sv
//==============================================================================
// Module   : tb_rf_arbiter
// Purpose  : Self-checking bench for rf_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [3:0] reg_no0 = '0, reg_no1 = '0;
    logic [3:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, err0, err1;
    logic [3:0] rdata0, rdata1;
    logic       rf_write_en;
    logic [3:0] rf_reg_no, rf_val, rf_dout;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_arbiter #(.DW(4), .RW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .reg_no0(reg_no0), .reg_no1(reg_no1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rf_write_en(rf_write_en), .rf_reg_no(rf_reg_no), .rf_val(rf_val),
        .rf_dout(rf_dout), .busy(busy)
    );

    // Register file environment: commits on the negedge, combinational read.
    logic [3:0] rf_mem [4] = '{default: 4'h0};
    always @(negedge clk) begin
        if (rf_write_en && rf_reg_no <= 4'd3) rf_mem[rf_reg_no[1:0]] <= rf_val;
    end
    assign rf_dout = (rf_reg_no <= 4'd3) ? rf_mem[rf_reg_no[1:0]] : 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an access occupies the two cycles after its grant.
    bit       m_valid = 1'b0;
    int       m_left  = 0;
    int       m_id, m_reg, m_wd, m_last = 1;
    bit       m_we;
    int       m_rdata [2] = '{0, 0};
    int       m_mem   [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        if (rst) begin
            if (m_left == 2 && m_we && m_reg <= 3) m_mem[m_reg] = m_wd;
            m_valid = 1'b1;
            m_left  = 0;
            m_rdata = '{0, 0};
            m_last  = 1;
        end else if (m_left == 0) begin
            if (req0 || req1) begin
`ifdef RF_ARB_RR_EN
                m_id = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
`else
                m_id = req0 ? 0 : 1;
`endif
                m_last = m_id;
                m_we   = (m_id == 0) ? we0 : we1;
                m_reg  = (m_id == 0) ? int'(reg_no0) : int'(reg_no1);
                m_wd   = (m_id == 0) ? int'(wdata0) : int'(wdata1);
                m_left = 2;
            end
        end else begin
            if (m_left == 2) begin
                if (m_reg > 3) begin
                    m_rdata[m_id] = 0;
                end else begin
                    if (m_we) m_mem[m_reg] = m_wd;
                    m_rdata[m_id] = m_mem[m_reg];
                end
            end
            m_left--;
        end
        #3;
        if (m_valid) begin
            chk("busy",        busy,        m_left != 0);
            chk("rf_write_en", rf_write_en, m_left == 2 && m_we && m_reg <= 3);
            chk("rf_reg_no",   rf_reg_no,   (m_left == 2) ? m_reg : 0);
            chk("rf_val",      rf_val,      (m_left == 2) ? m_wd : 0);
            chk("ack0",        ack0,        m_left == 1 && m_id == 0);
            chk("ack1",        ack1,        m_left == 1 && m_id == 1);
            chk("err0",        err0,        m_left == 1 && m_id == 0 && m_reg > 3);
            chk("err1",        err1,        m_left == 1 && m_id == 1 && m_reg > 3);
            chk("rdata0",      rdata0,      m_rdata[0]);
            chk("rdata1",      rdata1,      m_rdata[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants[$];
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        tick();

        // req0 writes reg 2 = 0xA, single-cycle request pulse
        req0 = 1'b1; we0 = 1'b1; reg_no0 = 4'd2; wdata0 = 4'hA;
        tick();
        chk("wr_en_access", rf_write_en, 1);
        chk("wr_reg_no", rf_reg_no, 2);
        chk("wr_val", rf_val, 4'hA);
        req0 = 1'b0; wdata0 = 4'h3;
        tick();
        chk("wr_ack0", ack0, 1);
        chk("wr_err0", err0, 0);
        chk("wr_rdata0", rdata0, 4'hA);
        chk("wr_en_done", rf_write_en, 0);
        chk("model_rdata0", m_rdata[0], 4'hA);
        tick();
        chk("wr_ack0_gone", ack0, 0);

        // req1 reads reg 2
        req1 = 1'b1; we1 = 1'b0; reg_no1 = 4'd2;
        tick();
        chk("rd_en", rf_write_en, 0);
        req1 = 1'b0;
        tick();
        chk("rd_ack1", ack1, 1);
        chk("rd_ack0", ack0, 0);
        chk("rd_rdata1", rdata1, 4'hA);
        chk("model_rdata1", m_rdata[1], 4'hA);
        tick();

        // Both requesters held high continuously
        req0 = 1'b1; we0 = 1'b0; reg_no0 = 4'd2;
        req1 = 1'b1; we1 = 1'b0; reg_no1 = 4'd3;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("both_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef RF_ARB_RR_EN
            chk("both_grant", grants[i], i % 2);
`else
            chk("both_grant", grants[i], 0);
`endif
        end

        // Out-of-range write
        req0 = 1'b1; we0 = 1'b1; reg_no0 = 4'd7; wdata0 = 4'h5;
        tick();
        chk("bad_wr_en", rf_write_en, 0);
        req0 = 1'b0;
        tick();
        chk("bad_ack0", ack0, 1);
        chk("bad_err0", err0, 1);
        chk("bad_rdata0", rdata0, 0);
        tick();

        // Reset during ACCESS of a req1 read
        req1 = 1'b1; we1 = 1'b0; reg_no1 = 4'd1;
        tick();
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1; req1 = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ack1", ack1, 0);
        tick();
        chk("abort_ack1_late", ack1, 0);
        chk("abort_busy_late", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            req0    = $urandom_range(0, 1);
            req1    = $urandom_range(0, 1);
            we0     = $urandom_range(0, 1);
            we1     = $urandom_range(0, 1);
            reg_no0 = 4'($urandom_range(0, 7));
            reg_no1 = 4'($urandom_range(0, 7));
            wdata0  = 4'($urandom);
            wdata1  = 4'($urandom);
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter: DW, 4, data width of the register-file value and read-back ports.
REQ-002 Parameter: RW, 4, width of the register-number field.
REQ-003 clk  input  1  system clock; all arbiter state updates on posedge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 we0 / we1  input  1  1 = write access, 0 = read access.
REQ-007 reg_no0 / reg_no1  input  RW  target register number.
REQ-008 wdata0 / wdata1  input  DW  write data.
REQ-009 ack0 / ack1  output  1  one-cycle pulse marking access complete.
REQ-010 err0 / err1  output  1  one-cycle pulse with ack when reg_no > 3.
REQ-011 rdata0 / rdata1  output  DW  read-back value; valid in the ack cycle and held until the next ack to that requester.
REQ-012 rf_write_en  output  1  write enable to the register file.
REQ-013 rf_reg_no  output  RW  register select to the register file.
REQ-014 rf_val  output  DW  write value to the register file.
REQ-015 rf_dout  input  DW  combinational read data from the register file.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS on any req sampled high.
- ACCESS -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-018 On the IDLE->ACCESS edge the arbiter SHALL latch the granted requester's id, we, reg_no and wdata; the requester may drop req or change its fields afterwards without affecting the access.
REQ-019 In ACCESS the arbiter SHALL drive rf_reg_no and rf_val from the latched fields, and drive rf_write_en = latched we AND (latched reg_no <= 3); the register file commits on the mid-cycle negedge.
REQ-020 In IDLE and DONE the arbiter SHALL drive rf_write_en = 0, rf_reg_no = 0 and rf_val = 0.
REQ-021 At the ACCESS->DONE posedge the arbiter SHALL capture rf_dout into the granted requester's rdata register.
- For writes the captured value equals the newly written value.
- For reg_no > 3 the captured value is 0.
REQ-022 In DONE the arbiter SHALL assert ack for the granted requester only.
- err is asserted with ack if the latched reg_no > 3.
- The other requester's ack and err stay 0.
REQ-023 Latency SHALL be: req high at posedge N (FSM in IDLE) -> ack high during cycle N+2; throughput is one access per 3 cycles.
REQ-024 A requester whose req is still high in DONE SHALL NOT be granted again until the FSM is back in IDLE, then arbitrates normally.
REQ-025 Requests arriving while busy SHALL be held off (no ack) until IDLE samples them; nothing is queued internally.
REQ-026 The arbiter SHALL keep a last-grant pointer, updated on every grant.

Reset
REQ-027 While rst is high at a posedge the arbiter SHALL:
- enter IDLE;
- clear ack0/1, err0/1, rdata0/1 to 0;
- set the last-grant pointer to 1;
- drive all rf_* outputs and busy to 0.
REQ-028 A reset asserted in ACCESS or DONE SHALL abort the access with no ack.
- A write already committed on the preceding negedge is not undone.

Configuration
REQ-029 Macro RF_ARB_RR_EN controls the arbitration policy.
- Defined: round-robin; with both req high in IDLE, the requester not equal to the last-grant pointer wins.
- Undefined: fixed priority; requester 0 always wins, the pointer is unused, and requester 1 is granted only when req0 is low in IDLE.

Verification
REQ-030 Directed scenarios the bench SHALL cover:
- Reset, then req0 write reg 2 = 0xA -> rf_write_en high exactly one cycle, rf_reg_no = 2, ack0 in cycle N+2, rdata0 = 0xA, err0 = 0.
- req1 read reg 2 after the previous write -> rf_write_en stays 0, ack1 in cycle N+2, rdata1 = 0xA.
- req0 and req1 both held high continuously -> with RF_ARB_RR_EN: grants alternate 0,1,0,1; without: all grants to requester 0.
- req0 write reg_no = 7 -> rf_write_en stays 0, ack0 and err0 pulse together, rdata0 = 0.
- rst asserted in ACCESS of a req1 read -> FSM in IDLE next cycle, ack1 never pulses, busy = 0.
- req0 pulsed for one cycle only -> access still completes and ack0 pulses in cycle N+2.
